// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/sub, DIGIT bits per clock,
// LSB digit first, registered carry between digits.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] a_d;
  logic [DIGIT-1:0] b_d;
  logic [DIGIT-1:0] s_d;
  logic [DIGIT:0]   d_sum;
  logic             c_d;
  logic             c_msb;
  logic             last;
  logic [WIDTH-1:0] acc_next;

  // One digit of the adder chain plus the next result-shift value
  always_comb begin
    a_d      = a_q[DIGIT-1:0];
    b_d      = b_q[DIGIT-1:0];
    d_sum    = {1'b0, a_d} + {1'b0, b_d}
             + {{DIGIT{1'b0}}, carry_q};
    s_d      = d_sum[DIGIT-1:0];
    c_d      = d_sum[DIGIT];
    // carry into the top bit of this digit
    c_msb    = a_d[DIGIT-1] ^ b_d[DIGIT-1]
             ^ s_d[DIGIT-1];
    last     = (cnt_q == CW'(NDIG - 1));
    acc_next = (acc_q >> DIGIT)
             | (WIDTH'(s_d) << (WIDTH - DIGIT));
  end

  // Control FSM, operand/result shifters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            a_q     <= A;
            b_q     <= B ^ {WIDTH{sub}};
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_next;
          carry_q <= c_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= acc_next;
            cout  <= c_d;
            ovf   <= c_msb ^ c_d;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed + random checks on three
// configurations with a done-driven scoreboard.
module tb_digit_serial_adder;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sub = 1'b0;
  logic cin = 1'b0;
  logic st8 = 1'b0;
  logic st88 = 1'b0;
  logic st32 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;

  logic bz8, dn8, co8, ov8;
  logic bz88, dn88, co88, ov88;
  logic bz32, dn32, co32, ov32;
  logic [7:0]  sm8, sm88;
  logic [31:0] sm32;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q8[$];
  exp_t q88[$];
  exp_t q32[$];
  exp_t e8, e88, e32;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .sub(sub),
    .A(a8), .B(b8), .cin(cin), .busy(bz8), .done(dn8),
    .sum(sm8), .cout(co8), .ovf(ov8));

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u88 (
    .clk(clk), .rst_n(rst_n), .start(st88), .sub(sub),
    .A(a8), .B(b8), .cin(cin), .busy(bz88), .done(dn88),
    .sum(sm88), .cout(co88), .ovf(ov88));

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) u32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .sub(sub),
    .A(a32), .B(b32), .cin(cin), .busy(bz32), .done(dn32),
    .sum(sm32), .cout(co32), .ovf(ov32));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: {ovf, cout, sum} from signed-sign rule
  function automatic logic [33:0] model(input int w,
      input logic [31:0] a, input logic [31:0] b,
      input logic ci, input logic sb);
    logic [63:0] mask, aa, bb, full;
    logic o;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'b0, a} & mask;
    bb   = {32'b0, (sb ? ~b : b)} & mask;
    full = aa + bb + 64'(ci ^ sb);
    o    = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return {o, full[w], full[31:0] & mask[31:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("u8_busy_done_excl", 32'(bz8 & dn8), 0);
      chk("u32_busy_done_excl", 32'(bz32 & dn32), 0);
      if (dn8) begin
        chk("u8_done_expected", 32'(q8.size() != 0), 1);
        if (q8.size() != 0) begin
          e8 = q8.pop_front();
          chk("u8_sum", 32'(sm8), e8.s);
          chk("u8_cout", 32'(co8), 32'(e8.c));
          chk("u8_ovf", 32'(ov8), 32'(e8.o));
          chk("u8_latency", cyc, e8.due);
        end
      end
      if (dn88) begin
        chk("u88_done_expected", 32'(q88.size() != 0), 1);
        if (q88.size() != 0) begin
          e88 = q88.pop_front();
          chk("u88_sum", 32'(sm88), e88.s);
          chk("u88_cout", 32'(co88), 32'(e88.c));
          chk("u88_ovf", 32'(ov88), 32'(e88.o));
          chk("u88_latency", cyc, e88.due);
        end
      end
      if (dn32) begin
        chk("u32_done_expected", 32'(q32.size() != 0), 1);
        if (q32.size() != 0) begin
          e32 = q32.pop_front();
          chk("u32_sum", sm32, e32.s);
          chk("u32_cout", 32'(co32), 32'(e32.c));
          chk("u32_ovf", 32'(ov32), 32'(e32.o));
          chk("u32_latency", cyc, e32.due);
        end
      end
    end
  end

  task automatic scramble();
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    a32 = $urandom;
    b32 = $urandom;
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sb,
                     input logic [7:0] es, input logic ec,
                     input logic eo);
    a8 = a; b8 = b; cin = ci; sub = sb; st8 = 1'b1;
    q8.push_back('{32'(es), ec, eo, cyc + 1 + 4});
    @(posedge clk); #1;
    st8 = 1'b0;
    scramble();
  endtask

  task automatic op88(input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sb,
                      input logic [7:0] es, input logic ec,
                      input logic eo);
    a8 = a; b8 = b; cin = ci; sub = sb; st88 = 1'b1;
    q88.push_back('{32'(es), ec, eo, cyc + 1 + 1});
    @(posedge clk); #1;
    st88 = 1'b0;
    scramble();
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic sb,
                      input logic [31:0] es, input logic ec,
                      input logic eo);
    a32 = a; b32 = b; cin = ci; sub = sb; st32 = 1'b1;
    q32.push_back('{es, ec, eo, cyc + 1 + 8});
    @(posedge clk); #1;
    st32 = 1'b0;
    scramble();
  endtask

  task automatic op8m(input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sb);
    logic [33:0] r;
    r = model(8, 32'(a), 32'(b), ci, sb);
    op8(a, b, ci, sb, r[7:0], r[32], r[33]);
  endtask

  task automatic op32m(input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb);
    logic [33:0] r;
    r = model(32, a, b, ci, sb);
    op32(a, b, ci, sb, r[31:0], r[32], r[33]);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 60 &&
         (q8.size() + q88.size() + q32.size()) != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain", 32'(q8.size() + q88.size() + q32.size()), 0);
  endtask

  initial begin
    // reset state
    @(posedge clk); #1;
    chk("rst_sum8", 32'(sm8), 0);
    chk("rst_flags8", {28'b0, bz8, dn8, co8, ov8}, 0);
    chk("rst_sum32", sm32, 0);
    chk("rst_flags32", {28'b0, bz32, dn32, co32, ov32}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FF + 01: busy profile and single-cycle done
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("busy_during_run", 32'(bz8), 1);
      @(posedge clk); #1;
    end
    chk("done_at_ndig", 32'(dn8), 1);
    chk("busy_off_at_done", 32'(bz8), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(dn8), 0);

    op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    drain();
    op8(8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
    drain();

    // 05 - 07 with an ignored start mid-operation
    op8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sum_held_midop", 32'(sm8), 32'h31);
    a8 = 8'hAA; b8 = 8'h55; sub = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    drain();
    repeat (8) @(posedge clk);
    #1;

    // 80 - 01 then back-to-back start on the done cycle
    op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("b2b_done_cycle", 32'(dn8), 1);
    op8(8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0);
    drain();

    // reset two cycles into an operation
    a8 = 8'h11; b8 = 8'h22; cin = 1'b0; sub = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sm8), 0);
    chk("abort_flags", {28'b0, bz8, dn8, co8, ov8}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done_sum", 32'(sm8), 0);
    op8(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 6; i++) begin
      op8m(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      drain();
    end

    // single-digit configuration
    op88(8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0);
    chk("u88_busy", 32'(bz88), 1);
    @(posedge clk); #1;
    chk("u88_done", 32'(dn88), 1);
    chk("u88_busy_off", 32'(bz88), 0);
    drain();
    op88(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    drain();

    // 32-bit, eight digits
    op32(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    drain();
    op32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) begin
      op32m($urandom, $urandom, 1'($urandom), 1'($urandom));
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor. It processes two WIDTH-bit operands DIGIT bits per clock, LSB digit first, through a DIGIT-bit full-adder chain with a registered inter-digit carry. It is the area-reduced, sequential successor to the single-bit full adder. It sits in datapaths where an adder of full WIDTH is too large and a latency of WIDTH/DIGIT cycles is acceptable, and uses a start/busy/done handshake.

## Interface
- WIDTH, 32, operand and result width in bits; must be ≥ 1.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly; DIGIT = WIDTH is legal.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled at the rising edge and accepted only when the block is idle.
- sub  in  1  mode, captured on accept: 0 gives A + B + cin; 1 gives A − B − cin (A + ~B + ~cin).
- A  in  WIDTH  operand A, captured on accept.
- B  in  WIDTH  operand B, captured on accept.
- cin  in  1  carry-in (add) or borrow-in (sub), captured on accept.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse when a result is ready.
- sum  out  WIDTH  result register; holds the last completed result.
- cout  out  1  carry-out of MSB; in sub mode 1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- NDIG = WIDTH/DIGIT. A digit counter of width clog2(NDIG), minimum 1 bit, counts 0..NDIG−1.
- FSM states: IDLE and RUN.
  - IDLE → RUN when start=1 at a rising edge. Capture A, B XOR {WIDTH{sub}} and carry = cin XOR sub; clear the digit counter.
  - RUN: each edge adds digit d of the captured operands plus the carry register, shifts the DIGIT-bit result into the internal result shift register, updates the carry register and increments d.
  - RUN → IDLE on the edge that processes digit NDIG−1.
- On the final-digit edge, sum, cout and ovf all load together; done goes high for exactly one cycle. ovf uses the carry into bit WIDTH−1 from the final digit's internal chain.
- sum, cout and ovf never change mid-operation; they hold the previous result until the next completion.
- start while busy=1 is ignored, with no effect on the operation in progress.
- start in the cycle where done=1 (busy=0) is accepted, giving back-to-back operation with no idle gap.
- Operand inputs are don't-care after capture.
- All arithmetic is modulo 2^WIDTH; the carry/borrow appears only on cout.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry=0, internal operand registers cleared.
- Reset mid-operation aborts immediately. No done is produced for the aborted operation and outputs read 0. The first start after rst_n rises is accepted normally.
- Let accept edge = E0.
  - busy is high from after E0 until after edge E0+NDIG.
  - done and the new sum/cout/ovf appear after edge E0+NDIG, i.e. a latency of NDIG cycles.
- Throughput is one result per NDIG cycles.
- busy and done are never high together.
- DIGIT = WIDTH: NDIG=1. busy is high for one cycle and done follows one edge after accept.

## Test plan
- WIDTH=8, DIGIT=2, add 8'hFF + 8'h01, cin=0 → done exactly 4 cycles after accept; sum=8'h00, cout=1, ovf=0; busy high for 4 cycles.
- Add 8'h7F + 8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Add 8'h10 + 8'h20, cin=1 → sum=8'h31, cout=0, ovf=0.
- sub=1: 8'h05 − 8'h07, cin=0 → sum=8'hFE, cout=0, ovf=0. 8'h80 − 8'h01 → sum=8'h7F, cout=1, ovf=1.
- Re-assert start with new operands 2 cycles into an operation → first result unaffected, no extra done. start on the done cycle → second result 4 cycles later with no gap.
- Drop rst_n for 1 cycle at cycle 2 of an operation → all outputs 0 at once, no done. A following 8'h03 + 8'h04 yields 8'h07.
- WIDTH=DIGIT=8: 8'hC8 + 8'h64 → sum=8'h2C, cout=1, done 1 cycle after accept. WIDTH=32, DIGIT=4: 32'hFFFFFFFF + 1 → sum=0, cout=1 after 8 cycles.
